// File: rtl/gs_pkg.sv
// Shared encodings for the gs memory stage: funct3 access sizes and the
// data-memory handshake state machine.
package gs_pkg;

  localparam logic [2:0] DS_B  = 3'b000;
  localparam logic [2:0] DS_H  = 3'b001;
  localparam logic [2:0] DS_W  = 3'b010;
  localparam logic [2:0] DS_BU = 3'b100;
  localparam logic [2:0] DS_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

  // funct3 codes with no load/store meaning
  function automatic logic size_illegal(input logic [2:0] ds);
    return (ds == 3'b011) || (ds == 3'b110) || (ds == 3'b111);
  endfunction

endpackage

// File: rtl/gs_mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave).
interface gs_mem_stage_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int BYTES     = 4
);
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [BYTES-1:0]     be;
  logic [WORD_SIZE-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [WORD_SIZE-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/gs_lsu_align.sv
// Combinational byte-lane logic: store lane replication and byte enables,
// load extraction with sign/zero extension, and misalignment/illegal-size faults.
module gs_lsu_align
  import gs_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int BYTES     = 4,
  parameter int OFF_W     = $clog2(BYTES)
) (
  input  logic                 is_mem_i,
  input  logic                 is_store_i,
  input  logic [2:0]           size_i,
  input  logic [OFF_W-1:0]     off_i,
  input  logic [WORD_SIZE-1:0] store_data_i,
  input  logic [WORD_SIZE-1:0] rdata_i,
  output logic [BYTES-1:0]     be_o,
  output logic [WORD_SIZE-1:0] wdata_o,
  output logic [WORD_SIZE-1:0] load_data_o,
  output logic                 fault_o
);

  logic [WORD_SIZE-1:0] shifted;

  always_comb begin
    shifted     = rdata_i >> {off_i, 3'b000};
    be_o        = '1;
    wdata_o     = store_data_i;
    load_data_o = shifted;
    fault_o     = 1'b0;

    // Sub-word stores replicate the datum across lanes so only be_o varies with offset
    if (is_store_i) begin
      case (size_i[1:0])
        2'b00: begin
          wdata_o = {BYTES{store_data_i[7:0]}};
          be_o    = {{(BYTES-1){1'b0}}, 1'b1} << off_i;
        end
        2'b01: begin
          wdata_o = {(BYTES/2){store_data_i[15:0]}};
          be_o    = {{(BYTES-2){1'b0}}, 2'b11} << off_i;
        end
        default: begin
          wdata_o = store_data_i;
          be_o    = '1;
        end
      endcase
    end

    case (size_i)
      DS_B:    load_data_o = {{(WORD_SIZE-8){shifted[7]}}, shifted[7:0]};
      DS_BU:   load_data_o = {{(WORD_SIZE-8){1'b0}}, shifted[7:0]};
      DS_H:    load_data_o = {{(WORD_SIZE-16){shifted[15]}}, shifted[15:0]};
      DS_HU:   load_data_o = {{(WORD_SIZE-16){1'b0}}, shifted[15:0]};
      default: load_data_o = shifted;
    endcase

    fault_o = is_mem_i &
              (size_illegal(size_i) |
               (((size_i == DS_H) | (size_i == DS_HU)) & off_i[0]) |
               ((size_i == DS_W) & (off_i != '0)));
  end

endmodule

// File: rtl/gs_mem_stage.sv
// Memory pipeline stage: holds one instruction from EX, runs the data-memory
// handshake for loads/stores, and registers the result toward write-back.
module gs_mem_stage
  import gs_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int BYTES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid_i,
  input  logic                 ex_MemWrite_i,
  input  logic                 ex_MemRead_i,
  input  logic [2:0]           ex_DataSize_i,
  input  logic [WORD_SIZE-1:0] ex_rs2_data_i,
  input  logic [ADDR_SIZE-1:0] ex_data_addr_i,
  input  logic                 ex_RegWrite_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic [WORD_SIZE-1:0] ex_rd_data_i,
  input  logic                 flush_mem_i,
  output logic                 mem_stall_o,
  gs_mem_stage_if.master       dmem,
  output logic                 wb_valid_o,
  output logic                 wb_RegWrite_o,
  output logic [4:0]           wb_rd_addr_o,
  output logic [WORD_SIZE-1:0] wb_rd_data_o,
  output logic                 mem_fault_o
);

  localparam int OFF_W = $clog2(BYTES);

  mem_state_e state_q, state_d;

  logic                 valid_q, valid_d;
  logic                 we_q, we_d;
  logic                 re_q, re_d;
  logic [2:0]           size_q, size_d;
  logic [WORD_SIZE-1:0] sdata_q, sdata_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 regw_q, regw_d;
  logic [4:0]           rd_q, rd_d;
  logic [WORD_SIZE-1:0] rdd_q, rdd_d;
  logic                 flushed_q, flushed_d;

  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_regw_q, wb_regw_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic                 wb_fault_q, wb_fault_d;

  logic                 is_mem;
  logic                 fault;
  logic [BYTES-1:0]     lane_be;
  logic [WORD_SIZE-1:0] lane_wdata;
  logic [WORD_SIZE-1:0] load_data;

  logic in_req, st_gnt, ld_gnt, ld_done, kill, done, leave, stall, capture, wb_en;

  gs_lsu_align #(
    .WORD_SIZE (WORD_SIZE),
    .BYTES     (BYTES)
  ) u_align (
    .is_mem_i     (is_mem),
    .is_store_i   (we_q),
    .size_i       (size_q),
    .off_i        (addr_q[OFF_W-1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (dmem.rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .load_data_o  (load_data),
    .fault_o      (fault)
  );

  always_comb begin
    is_mem  = we_q | re_q;
    in_req  = (state_q == S_REQ);
    st_gnt  = in_req & dmem.gnt & we_q;
    ld_gnt  = in_req & dmem.gnt & ~we_q;
    ld_done = (state_q == S_RESP) & dmem.rvalid;
    // A flush only discards before the grant; once granted the access must finish
    kill    = flush_mem_i & ((state_q == S_IDLE) | (in_req & ~dmem.gnt));
    done    = valid_q & (~is_mem | fault | st_gnt | ld_done);
    leave   = done | (valid_q & kill);
    stall   = valid_q & ~leave;
    capture = ex_valid_i & ~stall;
    wb_en   = done & ~flush_mem_i & ~flushed_q;
  end

  assign mem_stall_o  = stall;
  assign dmem.req     = in_req;
  assign dmem.we      = in_req & we_q;
  assign dmem.addr    = in_req ? {addr_q[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dmem.be      = in_req ? lane_be : '0;
  assign dmem.wdata   = in_req ? lane_wdata : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (valid_q & is_mem & ~fault & ~flush_mem_i) state_d = S_REQ;
      S_REQ: begin
        if (dmem.gnt)        state_d = we_q ? S_IDLE : S_RESP;
        else if (flush_mem_i) state_d = S_IDLE;
      end
      S_RESP:  if (dmem.rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    we_d      = we_q;
    re_d      = re_q;
    size_d    = size_q;
    sdata_d   = sdata_q;
    addr_d    = addr_q;
    regw_d    = regw_q;
    rd_d      = rd_q;
    rdd_d     = rdd_q;
    flushed_d = flushed_q;

    if (capture) begin
      valid_d   = 1'b1;
      we_d      = ex_MemWrite_i;
      re_d      = ex_MemRead_i;
      size_d    = ex_DataSize_i;
      sdata_d   = ex_rs2_data_i;
      addr_d    = ex_data_addr_i;
      regw_d    = ex_RegWrite_i;
      rd_d      = ex_rd_addr_i;
      rdd_d     = ex_rd_data_i;
      flushed_d = 1'b0;
    end else if (leave) begin
      valid_d   = 1'b0;
      flushed_d = 1'b0;
    end else if (flush_mem_i & valid_q & ((state_q == S_RESP) | ld_gnt)) begin
      // Granted load must drain its response; remember to drop the data
      flushed_d = 1'b1;
    end
  end

  always_comb begin
    wb_valid_d = wb_en;
    wb_regw_d  = 1'b0;
    wb_fault_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (wb_en) begin
      wb_regw_d  = regw_q & ~fault;
      wb_fault_d = fault;
      wb_rd_d    = rd_q;
      wb_data_d  = (re_q & ~fault) ? load_data : rdd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      size_q     <= '0;
      sdata_q    <= '0;
      addr_q     <= '0;
      regw_q     <= 1'b0;
      rd_q       <= '0;
      rdd_q      <= '0;
      flushed_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_regw_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      re_q       <= re_d;
      size_q     <= size_d;
      sdata_q    <= sdata_d;
      addr_q     <= addr_d;
      regw_q     <= regw_d;
      rd_q       <= rd_d;
      rdd_q      <= rdd_d;
      flushed_q  <= flushed_d;
      wb_valid_q <= wb_valid_d;
      wb_regw_q  <= wb_regw_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_RegWrite_o = wb_regw_q;
  assign wb_rd_addr_o  = wb_rd_q;
  assign wb_rd_data_o  = wb_data_q;
  assign mem_fault_o   = wb_fault_q;

endmodule

// File: tb/tb_gs_mem_stage.sv
// Scoreboarded bench for gs_mem_stage: expected write-backs are queued when
// an instruction is issued and compared when wb_valid_o pulses.
module tb_gs_mem_stage;
  import gs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_we, ex_re, ex_regw;
  logic [2:0]  ex_size;
  logic [31:0] ex_rs2, ex_addr, ex_rdd;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        stall;
  logic        wb_valid, wb_regw, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  gs_mem_stage_if #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4)) dmem ();

  gs_mem_stage #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid),
    .ex_MemWrite_i  (ex_we),
    .ex_MemRead_i   (ex_re),
    .ex_DataSize_i  (ex_size),
    .ex_rs2_data_i  (ex_rs2),
    .ex_data_addr_i (ex_addr),
    .ex_RegWrite_i  (ex_regw),
    .ex_rd_addr_i   (ex_rd),
    .ex_rd_data_i   (ex_rdd),
    .flush_mem_i    (flush),
    .mem_stall_o    (stall),
    .dmem           (dmem),
    .wb_valid_o     (wb_valid),
    .wb_RegWrite_o  (wb_regw),
    .wb_rd_addr_o   (wb_rd),
    .wb_rd_data_o   (wb_data),
    .mem_fault_o    (wb_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        flt;
    bit          chk_data;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   wb_cnt = 0;
  int   last_wb_cyc = 0;

  always @(posedge clk) cyc++;

  // Scoreboard: every retire must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      wb_cnt++;
      last_wb_cyc = cyc;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got retire rd=%0d data=%h, required no retire", wb_rd, wb_data);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (wb_rd !== e.rd || wb_regw !== e.rw || wb_fault !== e.flt) begin
          errors++;
          $display("FAIL wb_ctrl: got rd=%0d rw=%b flt=%b, required rd=%0d rw=%b flt=%b",
                   wb_rd, wb_regw, wb_fault, e.rd, e.rw, e.flt);
        end
        if (e.chk_data) begin
          checks++;
          if (wb_data !== e.data) begin
            errors++;
            $display("FAIL wb_data: got %h, required %h", wb_data, e.data);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic we, input logic re, input logic [2:0] sz,
                          input logic [31:0] rs2, input logic [31:0] addr,
                          input logic rw, input logic [4:0] rd, input logic [31:0] rdd);
    ex_valid = 1'b1; ex_we = we; ex_re = re; ex_size = sz;
    ex_rs2 = rs2; ex_addr = addr; ex_regw = rw; ex_rd = rd; ex_rdd = rdd;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic rw,
                      input logic flt, input bit chk);
    exp_t x;
    x.rd = rd; x.data = data; x.rw = rw; x.flt = flt; x.chk_data = chk;
    sbq.push_back(x);
  endtask

  // Plays the memory side from the cycle after capture until the completing edge
  task automatic run_access(input bit is_load, input int gw, input int rvw, input logic [31:0] rdv,
                            output int stalls, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                            output logic [3:0] o_be, output logic o_we);
    stalls = 0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    @(negedge clk); if (stall) stalls++;
    tick;
    for (int i = 0; i < gw; i++) begin
      @(negedge clk); if (stall) stalls++;
      tick;
    end
    dmem.gnt = 1'b1;
    @(negedge clk); if (stall) stalls++;
    o_addr = dmem.addr; o_wdata = dmem.wdata; o_be = dmem.be; o_we = dmem.we;
    tick;
    dmem.gnt = 1'b0;
    if (is_load) begin
      for (int i = 1; i < rvw; i++) begin
        @(negedge clk); if (stall) stalls++;
        tick;
      end
      dmem.rvalid = 1'b1; dmem.rdata = rdv;
      @(negedge clk); if (stall) stalls++;
      tick;
      dmem.rvalid = 1'b0; dmem.rdata = '0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ex_valid = 1'b0; ex_we = 1'b0; ex_re = 1'b0; ex_size = '0;
    ex_rs2 = '0; ex_addr = '0; ex_regw = 1'b0; ex_rd = '0; ex_rdd = '0; flush = 1'b0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if ({stall, dmem.req, dmem.we, wb_valid, wb_regw, wb_fault} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got stall/req/we/wbv/wbrw/flt=%b, required 000000",
               {stall, dmem.req, dmem.we, wb_valid, wb_regw, wb_fault});
    end
    checks++;
    if ({dmem.addr, dmem.be, dmem.wdata, wb_rd, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h be=%b wdata=%h rd=%0d data=%h, required all zero",
               dmem.addr, dmem.be, dmem.wdata, wb_rd, wb_data);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_store_lanes;
    logic [2:0]  t_sz[4]  = '{DS_B, DS_H, DS_W, DS_B};
    logic [31:0] t_ad[4]  = '{32'h1003, 32'h1002, 32'h1004, 32'h1000};
    logic [31:0] t_d[4]   = '{32'h000000A5, 32'h0000BEEF, 32'h12345678, 32'h0000007F};
    logic [3:0]  t_be[4]  = '{4'b1000, 4'b1100, 4'b1111, 4'b0001};
    logic [31:0] t_wd[4]  = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678, 32'h7F7F7F7F};
    int st, cap;
    logic [31:0] oa, ow;
    logic [3:0] ob;
    logic owe;
    for (int i = 0; i < 4; i++) begin
      drive_ex(1'b1, 1'b0, t_sz[i], t_d[i], t_ad[i], 1'b0, 5'd0, t_ad[i]);
      push(5'd0, t_ad[i], 1'b0, 1'b0, 1'b1);
      cap = cyc + 1;
      tick;
      ex_valid = 1'b0;
      run_access(1'b0, 0, 0, '0, st, oa, ow, ob, owe);
      tick;
      checks++;
      if (oa !== (t_ad[i] & 32'hFFFF_FFFC) || owe !== 1'b1) begin
        errors++;
        $display("FAIL store_addr[%0d]: got addr=%h we=%b, required addr=%h we=1", i, oa, owe, t_ad[i] & 32'hFFFF_FFFC);
      end
      checks++;
      if (ob !== t_be[i] || ow !== t_wd[i]) begin
        errors++;
        $display("FAIL store_lanes[%0d]: got be=%b wdata=%h, required be=%b wdata=%h", i, ob, ow, t_be[i], t_wd[i]);
      end
      checks++;
      if (st !== 1) begin errors++; $display("FAIL store_stall[%0d]: got %0d stall cycles, required 1", i, st); end
      checks++;
      if (last_wb_cyc - cap !== 2) begin
        errors++; $display("FAIL store_latency[%0d]: got %0d, required 2", i, last_wb_cyc - cap);
      end
    end
  endtask

  task automatic test_load_extend;
    logic [2:0]  t_sz[6] = '{DS_B, DS_BU, DS_H, DS_HU, DS_W, DS_B};
    logic [31:0] t_ad[6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2002, 32'h2000, 32'h2000};
    logic [31:0] t_rd[6] = '{32'h1280FF34, 32'h1280FF34, 32'h80011234, 32'h80011234, 32'hDEADBEEF, 32'h1280FF34};
    logic [31:0] t_ex[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hDEADBEEF, 32'h00000034};
    int st, cap;
    logic [31:0] oa, ow;
    logic [3:0] ob;
    logic owe;
    for (int i = 0; i < 6; i++) begin
      drive_ex(1'b0, 1'b1, t_sz[i], 32'h5555AAAA, t_ad[i], 1'b1, 5'(i + 1), 32'h0BAD0BAD);
      push(5'(i + 1), t_ex[i], 1'b1, 1'b0, 1'b1);
      cap = cyc + 1;
      tick;
      ex_valid = 1'b0;
      run_access(1'b1, 0, 1, t_rd[i], st, oa, ow, ob, owe);
      tick;
      checks++;
      if (oa !== 32'h2000 || ob !== 4'b1111 || owe !== 1'b0) begin
        errors++;
        $display("FAIL load_req[%0d]: got addr=%h be=%b we=%b, required 00002000 1111 0", i, oa, ob, owe);
      end
      checks++;
      if (st !== 2) begin errors++; $display("FAIL load_stall[%0d]: got %0d stall cycles, required 2", i, st); end
      checks++;
      if (last_wb_cyc - cap !== 3) begin
        errors++; $display("FAIL load_latency[%0d]: got %0d, required 3", i, last_wb_cyc - cap);
      end
    end
  endtask

  task automatic test_fault;
    logic [2:0]  t_sz[3] = '{DS_H, DS_W, 3'b011};
    logic [31:0] t_ad[3] = '{32'h2001, 32'h1002, 32'h2000};
    logic        t_we[3] = '{1'b0, 1'b1, 1'b0};
    int cap, reqs;
    for (int i = 0; i < 3; i++) begin
      drive_ex(t_we[i], ~t_we[i], t_sz[i], '0, t_ad[i], 1'b1, 5'd9, 32'h0);
      push(5'd9, '0, 1'b0, 1'b1, 1'b0);
      cap = cyc + 1;
      tick;
      ex_valid = 1'b0;
      reqs = 0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL fault_stall[%0d]: got %b, required 0", i, stall); end
      if (dmem.req) reqs++;
      tick;
      @(negedge clk); if (dmem.req) reqs++;
      tick;
      checks++;
      if (reqs !== 0) begin errors++; $display("FAIL fault_req[%0d]: got %0d request cycles, required 0", i, reqs); end
      checks++;
      if (last_wb_cyc - cap !== 1) begin
        errors++; $display("FAIL fault_latency[%0d]: got %0d, required 1", i, last_wb_cyc - cap);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cap, n0;
    n0 = wb_cnt;
    for (int i = 0; i < 3; i++) begin
      // middle op carries an illegal funct3 but is not a memory op, so no fault
      drive_ex(1'b0, 1'b0, (i == 1) ? 3'b011 : DS_W, '0, 32'h3, 1'b1, 5'(10 + i), 32'h100 * i + 32'h7);
      push(5'(10 + i), 32'h100 * i + 32'h7, 1'b1, 1'b0, 1'b1);
      if (i == 0) cap = cyc + 1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d]: got %b, required 0", i, stall); end
      tick;
    end
    ex_valid = 1'b0;
    tick; tick;
    checks++;
    if (wb_cnt - n0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d retires, required 3", wb_cnt - n0); end
    checks++;
    if (last_wb_cyc - cap !== 3) begin errors++; $display("FAIL b2b_latency: got %0d, required 3", last_wb_cyc - cap); end
  endtask

  task automatic test_lw_delayed;
    int cap, st, reqc, bad, n0;
    n0 = wb_cnt;
    st = 0; reqc = 0; bad = 0;
    drive_ex(1'b0, 1'b1, DS_W, '0, 32'h4008, 1'b1, 5'd7, 32'h0);
    push(5'd7, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1);
    cap = cyc + 1;
    tick;
    ex_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      dmem.gnt = (c == 5);
      dmem.rvalid = (c == 7);
      dmem.rdata = (c == 7) ? 32'hCAFEF00D : 32'h0;
      if (c == 3) begin
        drive_ex(1'b0, 1'b0, DS_W, '0, '0, 1'b1, 5'd8, 32'h00000042);
        push(5'd8, 32'h00000042, 1'b1, 1'b0, 1'b1);
      end
      @(negedge clk);
      if (stall) st++;
      if (dmem.req) begin
        reqc++;
        if (dmem.addr !== 32'h4008) bad++;
      end
      tick;
    end
    ex_valid = 1'b0; dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    tick; tick;
    checks++;
    if (st !== 6) begin errors++; $display("FAIL lw_stall: got %0d stall cycles, required 6", st); end
    checks++;
    if (reqc !== 4 || bad !== 0) begin
      errors++; $display("FAIL lw_req_hold: got %0d req cycles (%0d bad addr), required 4 (0)", reqc, bad);
    end
    checks++;
    if (wb_cnt - n0 !== 2) begin errors++; $display("FAIL lw_count: got %0d retires, required 2", wb_cnt - n0); end
    checks++;
    if (last_wb_cyc - cap !== 8) begin
      errors++; $display("FAIL lw_add_capture: got ADD retire at +%0d, required +8", last_wb_cyc - cap);
    end
  endtask

  task automatic test_flush;
    int n0;
    n0 = wb_cnt;
    // granted load flushed while waiting for data
    drive_ex(1'b0, 1'b1, DS_W, '0, 32'h3000, 1'b1, 5'd3, '0);
    tick; ex_valid = 1'b0;
    tick; dmem.gnt = 1'b1;
    tick; dmem.gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL flush_resp_stall0: got %b, required 1", stall); end
    tick; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL flush_resp_stall1: got %b, required 1", stall); end
    tick; dmem.rvalid = 1'b1; dmem.rdata = 32'h11111111;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_resp_release: got %b, required 0", stall); end
    tick; dmem.rvalid = 1'b0;
    // store flushed in S_REQ without a grant; a stray gnt afterwards is ignored
    drive_ex(1'b1, 1'b0, DS_W, 32'h77, 32'h3004, 1'b0, 5'd0, '0);
    tick; ex_valid = 1'b0;
    tick; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL flush_req_cycle: got req=%b stall=%b, required req=1 stall=0", dmem.req, stall);
    end
    tick; flush = 1'b0; dmem.gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b0) begin errors++; $display("FAIL flush_req_dropped: got req=%b, required 0", dmem.req); end
    tick; dmem.gnt = 1'b0;
    // flush coinciding with the grant of a store
    drive_ex(1'b1, 1'b0, DS_W, 32'h88, 32'h3008, 1'b0, 5'd0, '0);
    tick; ex_valid = 1'b0;
    tick; flush = 1'b1; dmem.gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL flush_gnt_store: got req=%b we=%b stall=%b, required 1 1 0", dmem.req, dmem.we, stall);
    end
    tick; flush = 1'b0; dmem.gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b0) begin errors++; $display("FAIL flush_gnt_after: got req=%b, required 0", dmem.req); end
    tick; tick;
    checks++;
    if (wb_cnt - n0 !== 0) begin errors++; $display("FAIL flush_no_wb: got %0d retires, required 0", wb_cnt - n0); end
  endtask

  task automatic test_reset_mid;
    int n0;
    n0 = wb_cnt;
    drive_ex(1'b0, 1'b1, DS_W, '0, 32'h5000, 1'b1, 5'd4, '0);
    tick; ex_valid = 1'b0;
    tick; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dmem.req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req: got %b, required 1", dmem.req); end
    tick; rst = 1'b0; dmem.gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({dmem.req, stall, wb_valid, wb_fault} !== 4'b0 || dmem.addr !== '0 || dmem.be !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got req=%b stall=%b wbv=%b flt=%b addr=%h be=%b, required all 0",
               dmem.req, stall, wb_valid, wb_fault, dmem.addr, dmem.be);
    end
    tick; dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h99999999;
    tick; dmem.rvalid = 1'b0;
    tick; tick;
    checks++;
    if (wb_cnt - n0 !== 0 || dmem.req !== 1'b0) begin
      errors++; $display("FAIL rstmid_late_resp: got %0d retires req=%b, required 0 retires req=0", wb_cnt - n0, dmem.req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_lanes();
    test_load_extend();
    test_fault();
    test_back_to_back();
    test_lw_delayed();
    test_flush();
    test_reset_mid();
    tick;
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d expected retires outstanding, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
